// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO input conditioner.
// Widths here size the per-bit debounce counter and the input bus.
package gpio_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

    localparam int GPIO_W         = 32;
    localparam int DIV_DEFAULT    = 50000;
    localparam int STABLE_DEFAULT = 4;
    // STABLE tops out at 15, so the run counter never exceeds 14.
    localparam int CNT_W          = 4;

    function automatic logic edge_match(input edge_mode_t mode,
                                        input logic rise,
                                        input logic fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit debouncer: accepts a new level after STABLE consecutive differing ticks,
// flagging selected edges in a sticky pending bit (set beats clear); no backpressure.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int         STABLE    = STABLE_DEFAULT,
    parameter edge_mode_t EDGE_MODE = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic sync_i,
    input  logic clr_i,
    output logic level_o,
    output logic pend_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pend_q, pend_d;
    logic             rise, fall, set;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (tick_i) begin
            if (sync_i == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = sync_i;
                cnt_d   = '0;
                rise    = sync_i;
                fall    = ~sync_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        set    = edge_match(EDGE_MODE, rise, fall);
        pend_d = set | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pend_q  <= pend_d;
        end
    end

    assign level_o = level_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronises, debounces and edge-flags 32 GPIO inputs; level latency 2 + STABLE*DIV clk
// worst case, irq is combinational from pending; no backpressure (clears are single-cycle strobes).
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int         DIV       = DIV_DEFAULT,
    parameter int         STABLE    = STABLE_DEFAULT,
    parameter edge_mode_t EDGE_MODE = EDGE_RISE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GPIO_W-1:0] raw_in,
    input  logic              clr_valid,
    input  logic [GPIO_W-1:0] clr_mask,
    output logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] pending,
    output logic              irq
);

    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < GPIO_W; g++) begin : g_bit
        debounce_bit #(
            .STABLE    (STABLE),
            .EDGE_MODE (EDGE_MODE)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_i  (tick),
            .sync_i  (sync2_q[g]),
            .clr_i   (clr_valid & clr_mask[g]),
            .level_o (gpio_in[g]),
            .pend_o  (pending[g])
        );
    end

    assign irq = |pending;

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter DIV, default 50000: tick period in clk cycles; legal range 2..2^20.
REQ-002 Parameter STABLE, default 4: consecutive differing tick samples required to accept a new level; legal range 2..15.
REQ-003 Parameter EDGE_MODE, default EDGE_RISE: pending-flag edge select, one of EDGE_RISE / EDGE_FALL / EDGE_BOTH.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 raw_in  in  32  asynchronous external switch/key levels.
REQ-007 clr_valid  in  1  qualifies clr_mask for one cycle.
REQ-008 clr_mask  in  32  write-1-to-clear mask for pending.
REQ-009 gpio_in  out  32  debounced level, registered; drives the CPU GPIO_in port.
REQ-010 pending  out  32  sticky per-bit edge flags, registered.
REQ-011 irq  out  1  OR-reduction of pending.

Function
REQ-012 Each raw_in bit SHALL pass through a 2-flop synchronizer; sync = raw_in delayed 2 clk.
REQ-013 Prescaler SHALL count 0..DIV-1 and wrap to 0; tick is high for exactly one cycle when count == DIV-1.
REQ-014 Per bit, on tick: if sync[i] == gpio_in[i], cnt[i] SHALL clear to 0.
REQ-015 Per bit, on tick: if sync[i] != gpio_in[i] and cnt[i] < STABLE-1, cnt[i] SHALL increment.
REQ-016 Per bit, on tick: if sync[i] != gpio_in[i] and cnt[i] == STABLE-1, gpio_in[i] SHALL load sync[i] and cnt[i] SHALL clear.
REQ-017 Off-tick cycles SHALL leave cnt and gpio_in unchanged.
REQ-018 Latency, clean step: gpio_in updates on the STABLE-th tick after sync changes; worst case 2 + STABLE*DIV cycles.
REQ-019 A level returning before STABLE ticks SHALL reset cnt and produce no gpio_in change (glitch rejected).
REQ-020 pending[i] SHALL be set on the same edge gpio_in[i] updates, if the transition matches EDGE_MODE.
REQ-021 pending[i] SHALL clear on the edge where clr_valid=1 and clr_mask[i]=1.
REQ-022 Simultaneous set and clear on the same bit: set SHALL win.
REQ-023 clr_mask is ignored when clr_valid=0; pending bits with clr_mask[i]=0 are unaffected.
REQ-024 irq SHALL be combinational from the pending register (no extra latency).

Reset
REQ-025 rst_n=0 at a clock edge SHALL zero sync flops, prescaler, all cnt, gpio_in, and pending; irq reads 0.
REQ-026 Reset mid-debounce SHALL discard partial counts; after release a full STABLE ticks are required again.
REQ-027 Reset SHALL dominate clr_valid and tick in the same cycle.

Structure
REQ-028 Package gpio_pkg SHALL hold the edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH), GPIO_W=32, and the DIV/STABLE defaults.
REQ-029 Per-bit logic (cnt, level, edge detect) SHALL live in sub-module debounce_bit, instantiated GPIO_W times via generate; prescaler and synchronizer stay in the top.

Verification (DIV=4, STABLE=3, EDGE_RISE unless stated)
REQ-030 Reset: raw_in=FFFFFFFF, rst_n=0 for 2 cycles -> gpio_in=0, pending=0, irq=0.
REQ-031 Clean step: raw_in[0] 0->1 held -> gpio_in[0]=1 within 14 cycles; pending[0]=1 and irq=1 on the same edge.
REQ-032 Glitch: raw_in[5]=1 for 6 cycles, then 0 -> gpio_in[5] stays 0; pending[5] stays 0 for 40 cycles.
REQ-033 Clear and collision: clr_valid=1, clr_mask=1 -> pending[0]=0 and irq=0 next cycle; clear bit 1 on its set edge -> pending[1]=1.
REQ-034 Reset mid-debounce: raw_in[3]=1, rst_n=0 after 2 ticks, release -> gpio_in[3]=0; it rises only after 3 further ticks.
REQ-035 EDGE_FALL: raw_in[7] 1->0 after a settled high -> pending[7]=1; the preceding rise sets nothing.
